frame_stream_demux4: RTL and testbench

- Demultiplexer counterpart to the design's 4:1 single-bit select muxes.
- Takes one pixel stream with a valid/ready handshake and SOF/EOF framing, and steers each whole frame to one of four output channels.
- Each output has a one-entry registered stage.
- Sits between the camera pixel front end and the four per-lane vision pipelines.
- A frame is never split across channels.

---
 rtl/frame_stream_demux4.sv | 131 +++++++++++++
 tb/tb_frame_stream_demux4.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_demux4.sv
// Steers whole SOF..EOF pixel frames to one of four registered output channels; FRAME_DEMUX_RR_EN picks the channel round-robin instead of sel.
// Latency: one clock from input acceptance to out_valid[i]; one beat per clock when the target drains.
// Backpressure: in_ready follows only the target channel's register; beats outside a frame are always taken and dropped.
module frame_stream_demux4 #(
    parameter int DATA_W     = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic                  in_eof,
    input  logic [1:0]            sel,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [3:0]            out_sof,
    output logic [3:0]            out_eof,
    output logic [1:0]            active_ch,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ROUTE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [1:0]            active_ch_q, active_ch_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [3:0]            vld_q, vld_d;
    logic [3:0]            sof_q, sof_d;
    logic [3:0]            eof_q, eof_d;
    logic [4*DATA_W-1:0]   data_q, data_d;

    logic [1:0] sof_target;
    logic [1:0] target;
    logic       can_load;
    logic       accept;
    logic       load;
    logic       ld_eof;

`ifdef FRAME_DEMUX_RR_EN
    logic [1:0] rr_q, rr_d;
    assign sof_target = rr_q;
`else
    assign sof_target = sel;
`endif

    assign target   = (state_q == ST_ROUTE) ? active_ch_q : sof_target;
    assign can_load = !vld_q[target] || out_ready[target];
    assign in_ready = ((state_q == ST_IDLE) && !in_sof) ? 1'b1 : can_load;
    assign accept   = in_valid && in_ready;
    assign load     = accept && ((state_q == ST_ROUTE) || in_sof);
    // An SOF inside a frame restarts it on the same channel, so the old frame gets no EOF.
    assign ld_eof   = in_eof && !((state_q == ST_ROUTE) && in_sof);

    always_comb begin
        state_d     = state_q;
        active_ch_d = active_ch_q;
        drop_cnt_d  = drop_cnt_q;
        vld_d       = vld_q & ~out_ready;
        sof_d       = sof_q;
        eof_d       = eof_q;
        data_d      = data_q;
`ifdef FRAME_DEMUX_RR_EN
        rr_d        = rr_q;
`endif
        if (load) begin
            vld_d[target]                     = 1'b1;
            sof_d[target]                     = in_sof;
            eof_d[target]                     = ld_eof;
            data_d[target*DATA_W +: DATA_W]   = in_data;
        end
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !in_sof && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
                if (load) begin
                    active_ch_d = target;
                    state_d     = in_eof ? ST_IDLE : ST_ROUTE;
`ifdef FRAME_DEMUX_RR_EN
                    rr_d        = rr_q + 2'd1;
`endif
                end
            end
            default: begin
                if (accept && in_eof && !in_sof) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            active_ch_q <= 2'd0;
            drop_cnt_q  <= '0;
            vld_q       <= 4'd0;
            sof_q       <= 4'd0;
            eof_q       <= 4'd0;
            data_q      <= '0;
`ifdef FRAME_DEMUX_RR_EN
            rr_q        <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            active_ch_q <= active_ch_d;
            drop_cnt_q  <= drop_cnt_d;
            vld_q       <= vld_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            data_q      <= data_d;
`ifdef FRAME_DEMUX_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_valid = vld_q;
    assign out_sof   = sof_q;
    assign out_eof   = eof_q;
    assign active_ch = active_ch_q;
    assign busy      = (state_q == ST_ROUTE);
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_frame_stream_demux4.sv
// Directed test-plan scenarios followed by random traffic, all checked every cycle
// against a frame-level reference model of the demux.
module tb_frame_stream_demux4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic        in_eof;
    logic [1:0]  sel;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [3:0]  out_sof;
    logic [3:0]  out_eof;
    logic [1:0]  active_ch;
    logic        busy;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: one held beat per channel plus frame ownership.
    bit       m_frame;
    int       m_ch;
    int       m_drop;
    int       m_rr;
    bit       m_acc;
    bit       hv[4];
    bit       hs[4];
    bit       he[4];
    bit [7:0] hd[4];

    always #5 clk = ~clk;

    frame_stream_demux4 #(.DATA_W(8), .DROP_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_sof(in_sof), .in_eof(in_eof), .sel(sel),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .active_ch(active_ch),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sof_tgt();
`ifdef FRAME_DEMUX_RR_EN
        return m_rr;
`else
        return int'(sel);
`endif
    endfunction

    function automatic bit exp_ready();
        int t;
        if (!m_frame && !in_sof) return 1'b1;
        t = m_frame ? m_ch : sof_tgt();
        return !hv[t] || out_ready[t];
    endfunction

    task automatic model_reset();
        m_frame = 0; m_ch = 0; m_drop = 0; m_rr = 0; m_acc = 0;
        for (int i = 0; i < 4; i++) begin
            hv[i] = 0; hs[i] = 0; he[i] = 0; hd[i] = 8'h00;
        end
    endtask

    task automatic put(input int ch, input bit [7:0] d, input bit s, input bit e);
        hv[ch] = 1; hd[ch] = d; hs[ch] = s; he[ch] = e;
    endtask

    task automatic model_update(input bit rdy);
        int t;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) if (hv[i] && out_ready[i]) hv[i] = 0;
        m_acc = in_valid && rdy;
        if (!m_frame) begin
            if (in_valid && !in_sof) begin
                if (m_drop < 65535) m_drop++;
            end else if (m_acc) begin
                t = sof_tgt();
                put(t, in_data, 1'b1, in_eof);
                m_ch    = t;
                m_frame = !in_eof;
                m_rr    = (m_rr + 1) % 4;
            end
        end else if (m_acc) begin
            put(m_ch, in_data, in_sof, in_sof ? 1'b0 : in_eof);
            if (in_eof && !in_sof) m_frame = 0;
        end
    endtask

    // One clock: compare every output at the falling edge, then advance the model.
    task automatic cyc();
        bit r;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("out_valid[%0d]", i), out_valid[i], hv[i]);
            if (hv[i]) begin
                chk($sformatf("out_data[%0d]", i), out_data[i*8 +: 8], hd[i]);
                chk($sformatf("out_sof[%0d]", i), out_sof[i], hs[i]);
                chk($sformatf("out_eof[%0d]", i), out_eof[i], he[i]);
            end
        end
        chk("busy", busy, m_frame);
        if (m_frame) chk("active_ch", active_ch, m_ch);
        chk("drop_cnt", drop_cnt, m_drop);
        r = exp_ready();
        chk("in_ready", in_ready, r);
        @(posedge clk);
        model_update(r);
        #1;
    endtask

    task automatic send(input bit [7:0] d, input bit s, input bit e, input bit [1:0] sl);
        in_valid = 1; in_data = d; in_sof = s; in_eof = e; sel = sl;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (m_acc) break;
        end
        chk("send_accept", m_acc, 1'b1);
        in_valid = 0; in_sof = 0; in_eof = 0;
    endtask

    initial begin
        rst = 1; in_data = 0; in_valid = 0; in_sof = 0; in_eof = 0; sel = 0;
        out_ready = 4'hF;
        model_reset();
        @(posedge clk); #1;
        cyc();
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_valid", out_valid, 4'h0);
        rst = 0;
        cyc();

`ifndef FRAME_DEMUX_RR_EN
        // Single frame of four beats to channel 2
        send(8'h11, 1, 0, 2'd2);
        chk("t1_valid0", out_valid, 4'b0100);
        chk("t1_sof0", out_sof[2], 1'b1);
        send(8'h22, 0, 0, 2'd0);
        chk("t1_data1", out_data[23:16], 8'h22);
        send(8'h33, 0, 0, 2'd1);
        send(8'h44, 0, 1, 2'd3);
        chk("t1_valid3", out_valid, 4'b0100);
        chk("t1_data3", out_data[23:16], 8'h44);
        chk("t1_eof3", out_eof[2], 1'b1);
        cyc(); cyc();

        // Backpressure on channel 1
        send(8'hA0, 1, 0, 2'd1);
        out_ready = 4'b1101;
        in_valid = 1; in_data = 8'hA1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t2_stall", in_ready, 1'b0);
            chk("t2_hold", out_data[15:8], 8'hA0);
        end
        out_ready = 4'hF;
        send(8'hA1, 0, 0, 2'd1);
        chk("t2_data1", out_data[15:8], 8'hA1);
        send(8'hA2, 0, 1, 2'd1);
        chk("t2_data2", out_data[15:8], 8'hA2);
        cyc(); cyc();

        // Pre-SOF drop
        rst = 1; cyc(); rst = 0;
        for (int k = 0; k < 3; k++) send(8'hD0 + 8'(k), 0, 0, 2'd0);
        cyc();
        chk("t3_drop", drop_cnt, 16'd3);
        chk("t3_none", out_valid, 4'h0);
        send(8'h51, 1, 0, 2'd0);
        send(8'h52, 0, 1, 2'd0);
        chk("t3_route", out_data[7:0], 8'h52);
        cyc();

        // Single-beat frame then a new frame next cycle
        send(8'h61, 1, 1, 2'd3);
        chk("t4_busy", busy, 1'b0);
        chk("t4_flags", {out_valid[3], out_sof[3], out_eof[3]}, 3'b111);
        send(8'h62, 1, 0, 2'd0);
        chk("t4_ch0", out_data[7:0], 8'h62);
        send(8'h63, 0, 1, 2'd2);
        cyc();

        // Reset mid-frame
        send(8'h71, 1, 0, 2'd0);
        send(8'h72, 0, 0, 2'd0);
        out_ready = 4'b1110;
        rst = 1; cyc(); rst = 0;
        chk("t5_valid", out_valid, 4'h0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_drop", drop_cnt, 16'd0);
        send(8'h73, 0, 0, 2'd0);
        send(8'h74, 0, 1, 2'd0);
        chk("t5_drop2", drop_cnt, 16'd2);
        out_ready = 4'hF;
        cyc();
`else
        // Round-robin: five single-beat frames with sel fixed at 2
        for (int k = 0; k < 5; k++) begin
            send(8'h80 + 8'(k), 1, 1, 2'd2);
            chk("rr_valid", out_valid, 4'b0001 << (k % 4));
        end
        cyc();
`endif

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            rst       = ($urandom_range(199) == 0);
            in_valid  = ($urandom_range(3) != 0);
            in_sof    = ($urandom_range(5) == 0);
            in_eof    = ($urandom_range(3) == 0);
            sel       = 2'($urandom_range(3));
            in_data   = 8'($urandom);
            for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(3) != 0);
            cyc();
        end
        rst = 0; in_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
